// File: rtl/fft_host_link.sv
// Host-side link for the FFT core: streams N samples from the sample memory to the core (AR),
// collects N results from the core (AW) into the result memory, one transform per start pulse.
module fft_host_link #(
    parameter int DATA_WIDTH = 32,
    parameter int RES_WIDTH  = 33,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_samples_number,
    output logic [ADDR_WIDTH-1:0] o_smp_addr,
    output logic                  o_smp_rd,
    input  logic [DATA_WIDTH-1:0] i_smp_data,
    output logic [DATA_WIDTH-1:0] o_ARDATA,
    output logic                  o_ARVALID,
    input  logic                  i_ARREADY,
    input  logic [RES_WIDTH-1:0]  i_AWDATA,
    input  logic                  i_AWVALID,
    output logic                  o_AWREADY,
    output logic [ADDR_WIDTH-1:0] o_res_addr,
    output logic [RES_WIDTH-1:0]  o_res_data,
    output logic                  o_res_we,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err_unexpected
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] n_q, n_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] smp_cnt_q, smp_cnt_d;
    logic [ADDR_WIDTH-1:0] res_cnt_q, res_cnt_d;
    logic                  arr_q, arr_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic                  fifo_wr_q, fifo_wr_d;
    logic                  fifo_rd_q, fifo_rd_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;
    logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
    logic [RES_WIDTH-1:0]  res_data_q, res_data_d;
    logic                  res_we_q, res_we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic       ar_valid, ar_hs, aw_ready, aw_hs, smp_rd;
    logic [1:0] occ;

    // arr_q marks a read issued last cycle whose data is on i_smp_data now.
    // occ is FIFO occupancy plus that read, net of this cycle's pop, so a
    // pop frees a slot immediately and one sample per cycle is sustained.
    assign ar_valid = (fifo_cnt_q != 2'd0);
    assign ar_hs    = ar_valid && i_ARREADY;
    assign aw_ready = (state_q == S_RUN) && (res_cnt_q < n_q);
    assign aw_hs    = i_AWVALID && aw_ready;
    assign occ      = fifo_cnt_q + {1'b0, arr_q} - {1'b0, ar_hs};
    assign smp_rd   = (state_q == S_RUN) && (rd_ptr_q < n_q) && (occ < 2'd2);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        rd_ptr_d   = rd_ptr_q;
        smp_cnt_d  = smp_cnt_q;
        res_cnt_d  = res_cnt_q;
        arr_d      = smp_rd;
        fifo_d     = fifo_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = occ;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;
        res_we_d   = aw_hs;
        err_d      = err_q | (i_AWVALID & ~aw_ready);

        if (arr_q) begin
            fifo_d[fifo_wr_q] = i_smp_data;
            fifo_wr_d         = ~fifo_wr_q;
        end
        if (ar_hs) begin
            fifo_rd_d = ~fifo_rd_q;
            smp_cnt_d = smp_cnt_q + ADDR_ONE;
        end
        if (smp_rd) begin
            rd_ptr_d = rd_ptr_q + ADDR_ONE;
        end
        if (aw_hs) begin
            res_data_d = i_AWDATA;
            res_addr_d = res_cnt_q;
            res_cnt_d  = res_cnt_q + ADDR_ONE;
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    n_d        = i_samples_number;
                    rd_ptr_d   = '0;
                    smp_cnt_d  = '0;
                    res_cnt_d  = '0;
                    arr_d      = 1'b0;
                    fifo_wr_d  = 1'b0;
                    fifo_rd_d  = 1'b0;
                    fifo_cnt_d = 2'd0;
                    err_d      = 1'b0;
                    state_d    = (i_samples_number == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if ((smp_cnt_d == n_q) && (res_cnt_d == n_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            rd_ptr_q   <= '0;
            smp_cnt_q  <= '0;
            res_cnt_q  <= '0;
            arr_q      <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
            res_addr_q <= '0;
            res_data_q <= '0;
            res_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            rd_ptr_q   <= rd_ptr_d;
            smp_cnt_q  <= smp_cnt_d;
            res_cnt_q  <= res_cnt_d;
            arr_q      <= arr_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
            res_we_q   <= res_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
        fifo_q <= fifo_d;
    end

    // The FIFO storage is not reset, so the head is masked while empty.
    assign o_ARDATA         = ar_valid ? fifo_q[fifo_rd_q] : '0;
    assign o_ARVALID        = ar_valid;
    assign o_AWREADY        = aw_ready;
    assign o_smp_rd         = smp_rd;
    assign o_smp_addr       = rd_ptr_q;
    assign o_res_addr       = res_addr_q;
    assign o_res_data       = res_data_q;
    assign o_res_we         = res_we_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_err_unexpected = err_q;
endmodule

// File: tb/tb_fft_host_link.sv
// Directed bench for fft_host_link: sample memory model plus per-scenario tasks with
// hand-derived cycle timelines relative to the start-accepting edge.
module tb_fft_host_link;
    localparam int DW = 32;
    localparam int RW = 33;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          i_rst, i_start;
    logic [AW-1:0] i_samples_number;
    logic [AW-1:0] o_smp_addr;
    logic          o_smp_rd;
    logic [DW-1:0] i_smp_data;
    logic [DW-1:0] o_ARDATA;
    logic          o_ARVALID, i_ARREADY;
    logic [RW-1:0] i_AWDATA;
    logic          i_AWVALID, o_AWREADY;
    logic [AW-1:0] o_res_addr;
    logic [RW-1:0] o_res_data;
    logic          o_res_we, o_busy, o_done, o_err_unexpected;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] mem [0:15];

    always #5 clk = ~clk;

    // Sample memory: one-cycle read latency, junk when not reading.
    always @(posedge clk) i_smp_data <= o_smp_rd ? mem[o_smp_addr[3:0]] : 32'hDEAD_BEEF;

    fft_host_link #(.DATA_WIDTH(DW), .RES_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_samples_number(i_samples_number),
        .o_smp_addr(o_smp_addr), .o_smp_rd(o_smp_rd), .i_smp_data(i_smp_data),
        .o_ARDATA(o_ARDATA), .o_ARVALID(o_ARVALID), .i_ARREADY(i_ARREADY),
        .i_AWDATA(i_AWDATA), .i_AWVALID(i_AWVALID), .o_AWREADY(o_AWREADY),
        .o_res_addr(o_res_addr), .o_res_data(o_res_data), .o_res_we(o_res_we),
        .o_busy(o_busy), .o_done(o_done), .o_err_unexpected(o_err_unexpected)
    );

    task automatic fill_mem(input logic [DW-1:0] base);
        for (int i = 0; i < 16; i++) mem[i] = base + DW'(i);
    endtask

    // Leaves the bench 1 time unit into cycle k+1 (k = start-accepting edge).
    task automatic start_xfer(input int n);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_samples_number = AW'(n);
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_start = 1'b0; i_samples_number = '0;
        i_ARREADY = 1'b0; i_AWVALID = 1'b0; i_AWDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({o_smp_addr, o_smp_rd, o_ARDATA, o_ARVALID, o_AWREADY, o_res_addr, o_res_data,
             o_res_we, o_busy, o_done, o_err_unexpected} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got smp_rd=%b arvalid=%b awready=%b we=%b busy=%b done=%b err=%b required all 0",
                     o_smp_rd, o_ARVALID, o_AWREADY, o_res_we, o_busy, o_done, o_err_unexpected);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_basic;
        fill_mem(32'h0001_0000);
        i_ARREADY = 1'b1;
        start_xfer(4);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            i_AWVALID = (c >= 7 && c <= 10);
            i_AWDATA  = (c >= 7) ? 33'h1_0000_0000 + RW'(c - 7) : '0;
            #1;
            total++;
            if (o_smp_rd !== (c <= 4)) begin
                bad++; $display("FAIL basic_smp_rd c=%0d got=%b required=%b", c, o_smp_rd, (c <= 4));
            end
            if (c <= 4) begin
                total++;
                if (o_smp_addr !== AW'(c - 1)) begin
                    bad++; $display("FAIL basic_smp_addr c=%0d got=%0d required=%0d", c, o_smp_addr, c - 1);
                end
            end
            total++;
            if (o_ARVALID !== (c >= 3 && c <= 6)) begin
                bad++; $display("FAIL basic_arvalid c=%0d got=%b required=%b", c, o_ARVALID, (c >= 3 && c <= 6));
            end
            if (c >= 3 && c <= 6) begin
                total++;
                if (o_ARDATA !== 32'h0001_0000 + DW'(c - 3)) begin
                    bad++; $display("FAIL basic_ardata c=%0d got=%h required=%h", c, o_ARDATA, 32'h0001_0000 + DW'(c - 3));
                end
            end
            total++;
            if (o_res_we !== (c >= 8 && c <= 11)) begin
                bad++; $display("FAIL basic_res_we c=%0d got=%b required=%b", c, o_res_we, (c >= 8 && c <= 11));
            end
            if (c >= 8 && c <= 11) begin
                total++;
                if (o_res_addr !== AW'(c - 8) || o_res_data !== 33'h1_0000_0000 + RW'(c - 8)) begin
                    bad++; $display("FAIL basic_res_write c=%0d got addr=%0d data=%h required addr=%0d data=%h",
                                    c, o_res_addr, o_res_data, c - 8, 33'h1_0000_0000 + RW'(c - 8));
                end
            end
            total++;
            if (o_done !== (c == 11) || o_busy !== (c <= 11)) begin
                bad++; $display("FAIL basic_done_busy c=%0d got done=%b busy=%b required done=%b busy=%b",
                                c, o_done, o_busy, (c == 11), (c <= 11));
            end
        end
        i_AWVALID = 1'b0;
    endtask

    task automatic test_stall;
        int exp_idx = 0;
        int issued = 0;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        fill_mem(32'h0005_0000);
        i_ARREADY = 1'b0;
        start_xfer(8);
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            i_ARREADY = (c % 2 == 1);
            #1;
            if (o_smp_rd) begin
                total++;
                if (o_smp_addr !== AW'(issued)) begin
                    bad++; $display("FAIL stall_smp_addr c=%0d got=%0d required=%0d", c, o_smp_addr, issued);
                end
                issued++;
            end
            if (prev_stall) begin
                total++;
                if (o_ARVALID !== 1'b1 || o_ARDATA !== prev_data) begin
                    bad++; $display("FAIL stall_hold c=%0d got valid=%b data=%h required valid=1 data=%h",
                                    c, o_ARVALID, o_ARDATA, prev_data);
                end
            end
            if (o_ARVALID) begin
                total++;
                if (o_ARDATA !== 32'h0005_0000 + DW'(exp_idx)) begin
                    bad++; $display("FAIL stall_ardata c=%0d got=%h required=%h", c, o_ARDATA, 32'h0005_0000 + DW'(exp_idx));
                end
                if (i_ARREADY) exp_idx++;
            end
            total++;
            if (issued - exp_idx > 2 || o_done !== 1'b0) begin
                bad++; $display("FAIL stall_outstanding c=%0d got outstanding=%0d done=%b required <=2 done=0",
                                c, issued - exp_idx, o_done);
            end
            prev_stall = o_ARVALID && !i_ARREADY;
            prev_data  = o_ARDATA;
        end
        total++;
        if (exp_idx != 8 || issued != 8) begin
            bad++; $display("FAIL stall_count got sent=%0d reads=%0d required 8 and 8", exp_idx, issued);
        end
        i_ARREADY = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(posedge clk); #1;
            i_AWVALID = (c < 8);
            i_AWDATA  = 33'h0_0000_0100 + RW'(c);
            #1;
            total++;
            if (o_res_we !== (c >= 1 && c <= 8) || o_done !== (c == 8)) begin
                bad++; $display("FAIL stall_results c=%0d got we=%b done=%b required we=%b done=%b",
                                c, o_res_we, o_done, (c >= 1 && c <= 8), (c == 8));
            end
            if (c >= 1 && c <= 8) begin
                total++;
                if (o_res_addr !== AW'(c - 1) || o_res_data !== 33'h0_0000_0100 + RW'(c - 1)) begin
                    bad++; $display("FAIL stall_res_write c=%0d got addr=%0d data=%h required addr=%0d", c, o_res_addr, o_res_data, c - 1);
                end
            end
        end
        i_AWVALID = 1'b0;
    endtask

    task automatic test_interleave;
        logic [15:0] aw_mask = 16'b0001_0110_1011_0000;
        int k = 0;
        logic we_exp = 1'b0;
        fill_mem(32'h0002_0000);
        i_ARREADY = 1'b1;
        start_xfer(6);
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            i_AWVALID = aw_mask[c];
            i_AWDATA  = 33'h1_2000_0000 + RW'(k);
            #1;
            total++;
            if (o_res_we !== we_exp) begin
                bad++; $display("FAIL inter_res_we c=%0d got=%b required=%b", c, o_res_we, we_exp);
            end
            if (we_exp) begin
                total++;
                if (o_res_addr !== AW'(k - 1) || o_res_data !== 33'h1_2000_0000 + RW'(k - 1)) begin
                    bad++; $display("FAIL inter_res_write c=%0d got addr=%0d data=%h required addr=%0d", c, o_res_addr, o_res_data, k - 1);
                end
            end
            total++;
            if (o_ARVALID !== (c >= 3 && c <= 8) ||
                (c >= 3 && c <= 8 && o_ARDATA !== 32'h0002_0000 + DW'(c - 3))) begin
                bad++; $display("FAIL inter_ar c=%0d got valid=%b data=%h", c, o_ARVALID, o_ARDATA);
            end
            total++;
            if (o_AWREADY !== (c <= 12) || o_done !== (c == 13)) begin
                bad++; $display("FAIL inter_ready_done c=%0d got awready=%b done=%b required awready=%b done=%b",
                                c, o_AWREADY, o_done, (c <= 12), (c == 13));
            end
            we_exp = i_AWVALID && (c <= 12);
            if (we_exp) k++;
        end
        i_AWVALID = 1'b0;
        total++;
        if (o_err_unexpected !== 1'b0 || k != 6) begin
            bad++; $display("FAIL inter_final got err=%b results=%0d required err=0 results=6", o_err_unexpected, k);
        end
    endtask

    task automatic test_zero;
        start_xfer(0);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            #1;
            total++;
            if (o_done !== (c == 1) || o_busy !== (c == 1) ||
                {o_smp_rd, o_ARVALID, o_res_we} !== 3'b000) begin
                bad++; $display("FAIL zero_n c=%0d got done=%b busy=%b smp_rd=%b arvalid=%b we=%b required done=busy=%b strobes 0",
                                c, o_done, o_busy, o_smp_rd, o_ARVALID, o_res_we, (c == 1));
            end
        end
    endtask

    task automatic test_reset_mid;
        fill_mem(32'h0004_0000);
        i_ARREADY = 1'b1;
        start_xfer(10);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 4) i_rst = 1'b1;
            #1;
            if (c >= 3) begin
                total++;
                if (o_ARVALID !== 1'b1 || o_ARDATA !== 32'h0004_0000 + DW'(c - 3)) begin
                    bad++; $display("FAIL rstmid_ar c=%0d got valid=%b data=%h", c, o_ARVALID, o_ARDATA);
                end
            end
        end
        @(posedge clk); #1;
        i_rst = 1'b0;
        #1;
        total++;
        if ({o_smp_addr, o_smp_rd, o_ARDATA, o_ARVALID, o_AWREADY, o_res_addr, o_res_data,
             o_res_we, o_busy, o_done, o_err_unexpected} !== '0) begin
            bad++; $display("FAIL rstmid_outputs got smp_rd=%b arvalid=%b awready=%b busy=%b required all 0",
                            o_smp_rd, o_ARVALID, o_AWREADY, o_busy);
        end
        fill_mem(32'h0003_0000);
        start_xfer(3);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            i_AWVALID = (c >= 6 && c <= 8);
            i_AWDATA  = 33'h0_0000_0AAA + RW'(c);
            #1;
            if (c == 1) begin
                total++;
                if (o_smp_rd !== 1'b1 || o_smp_addr !== '0) begin
                    bad++; $display("FAIL rstmid_restart_addr got rd=%b addr=%0d required rd=1 addr=0", o_smp_rd, o_smp_addr);
                end
            end
            total++;
            if (o_ARVALID !== (c >= 3 && c <= 5) ||
                (c >= 3 && c <= 5 && o_ARDATA !== 32'h0003_0000 + DW'(c - 3))) begin
                bad++; $display("FAIL rstmid_restart_ar c=%0d got valid=%b data=%h", c, o_ARVALID, o_ARDATA);
            end
            total++;
            if (o_res_we !== (c >= 7 && c <= 9) || o_done !== (c == 9) ||
                (c >= 7 && c <= 9 && o_res_addr !== AW'(c - 7))) begin
                bad++; $display("FAIL rstmid_restart_res c=%0d got we=%b addr=%0d done=%b required we=%b done=%b",
                                c, o_res_we, o_res_addr, o_done, (c >= 7 && c <= 9), (c == 9));
            end
        end
        i_AWVALID = 1'b0;
    endtask

    task automatic test_err;
        @(posedge clk); #1;
        i_AWVALID = 1'b1;
        #1;
        total++;
        if (o_err_unexpected !== 1'b0) begin
            bad++; $display("FAIL err_before got=%b required=0", o_err_unexpected);
        end
        @(posedge clk); #1;
        i_AWVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (o_err_unexpected !== 1'b1) begin
                bad++; $display("FAIL err_sticky c=%0d got=%b required=1", c, o_err_unexpected);
            end
            @(posedge clk); #1;
        end
        start_xfer(0);
        #1;
        total++;
        if (o_err_unexpected !== 1'b0) begin
            bad++; $display("FAIL err_clear_on_start got=%b required=0", o_err_unexpected);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_interleave();
        test_zero();
        test_reset_mid();
        test_err();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
